// File: rtl/uart_image_loader.sv
// uart_image_loader: parses a sync/width/height header from UART bytes and writes
// one thresholded bit per following pixel byte into a {row, col} frame buffer.
module uart_image_loader #(
    parameter int         XW      = 6,
    parameter int         YW      = 6,
    parameter logic [7:0] SYNC    = 8'hA5,
    parameter logic [7:0] THRESH  = 8'd128,
    parameter int         TIMEOUT = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             ready,
    output logic             wr_en,
    output logic [XW+YW-1:0] wr_addr,
    output logic             wr_data,
    output logic [XW:0]      width,
    output logic [YW:0]      height,
    output logic             busy,
    output logic             frame_done,
    output logic             err
);
    localparam int WW = XW + 1;
    localparam int HW = YW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, GET_W, GET_H, PIXELS, DONE} state_t;

    state_t        state;
    logic          ready_d;
    logic [TW-1:0] idle_cnt;
    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic          accept, last_col, last_row, w_bad, h_bad, timed_out;

    assign accept    = ready && !ready_d;
    assign last_col  = {1'b0, col} == width - 1'b1;
    assign last_row  = {1'b0, row} == height - 1'b1;
    assign w_bad     = rx_data == 8'd0 || int'(rx_data) > (1 << XW);
    assign h_bad     = rx_data == 8'd0 || int'(rx_data) > (1 << YW);
    assign timed_out = (state == GET_W || state == GET_H || state == PIXELS) && !accept && idle_cnt == TMAX;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ready_d    <= 1'b0;
            idle_cnt   <= '0;
            col        <= '0;
            row        <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 1'b0;
            width      <= '0;
            height     <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            ready_d    <= ready;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            idle_cnt   <= (state == IDLE || accept) ? '0 : idle_cnt + 1'b1;
            if (timed_out) begin
                err   <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (accept && rx_data == SYNC) begin
                        busy  <= 1'b1;
                        state <= GET_W;
                    end
                    GET_W: if (accept) begin
                        err   <= w_bad;
                        busy  <= !w_bad;
                        state <= w_bad ? IDLE : GET_H;
                        if (!w_bad) width <= WW'(rx_data);
                    end
                    GET_H: if (accept) begin
                        err   <= h_bad;
                        busy  <= !h_bad;
                        state <= h_bad ? IDLE : PIXELS;
                        col   <= '0;
                        row   <= '0;
                        if (!h_bad) height <= HW'(rx_data);
                    end
                    PIXELS: if (accept) begin
                        wr_en   <= 1'b1;
                        wr_addr <= {row, col};
                        wr_data <= rx_data >= THRESH;
                        col     <= last_col ? '0 : col + 1'b1;
                        row     <= last_col ? row + 1'b1 : row;
                        if (last_col && last_row) state <= DONE;
                    end
                    DONE: begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_image_loader.sv
// tb_uart_image_loader: directed and random frames checked against a
// frame-level reference model of header parsing and pixel addressing.
module tb_uart_image_loader;
    logic        clk, rst, ready;
    logic [7:0]  rx_data;
    logic        wr_en, wr_data, busy, frame_done, err;
    logic [11:0] wr_addr;
    logic [6:0]  width, height;

    int n_checks, n_fail, cyc, t_acc;
    int n_wr_seen, n_err_seen, n_done_seen;
    int m_state, m_w, m_h, m_n, m_wr, m_err, m_done;

    uart_image_loader #(.XW(6), .YW(6), .SYNC(8'hA5), .THRESH(8'd128), .TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .ready(ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .width(width), .height(height), .busy(busy),
        .frame_done(frame_done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (!rst) begin
        if (wr_en) n_wr_seen++;
        if (err) n_err_seen++;
        if (frame_done) n_done_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_width", width, 0);
        check("rst_height", height, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", err, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ready = 1'b0;
        rx_data = 8'h00;
        #1;
        check_reset_values();
        repeat (2) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        m_state = 0;
        @(negedge clk);
    endtask

    // Entered and left on a negedge; model predicts the outcome of byte b.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit e_wr = 0, e_err = 0, e_done = 0, e_d = 0, hdr = 0;
        int e_addr = 0;
        case (m_state)
            0: if (b == 8'hA5) m_state = 1;
            1: if (b == 0 || b > 64) begin e_err = 1; m_state = 0; end
               else begin m_w = b; m_state = 2; end
            2: if (b == 0 || b > 64) begin e_err = 1; m_state = 0; end
               else begin m_h = b; m_n = 0; m_state = 3; hdr = 1; end
            default: begin
                e_wr = 1;
                e_addr = (m_n / m_w) * 64 + m_n % m_w;
                e_d = b >= 128;
                m_n++;
                if (m_n == m_w * m_h) begin e_done = 1; m_state = 0; end
            end
        endcase
        m_wr += int'(e_wr);
        m_err += int'(e_err);
        m_done += int'(e_done);
        rx_data = b;
        ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_acc = cyc;
        check("wr_en", wr_en, e_wr);
        if (e_wr) begin
            check("wr_addr", wr_addr, e_addr);
            check("wr_data", wr_data, e_d);
        end
        check("err", err, e_err);
        check("busy", busy, m_state != 0 || e_done);
        if (hdr) begin
            check("width", width, m_w);
            check("height", height, m_h);
        end
        ready = 1'b0;
        @(negedge clk);
        check("frame_done", frame_done, e_done);
        check("wr_single", wr_en, 0);
        if (e_done) check("busy_after_done", busy, 0);
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] nominal[9] = '{8'hA5, 8'h03, 8'h02, 8'h00, 8'hFF, 8'h80, 8'h7F, 8'h10, 8'hC8};
        int r, w, h, found;
        logic [7:0] g;
        do_reset();

        foreach (nominal[i]) send_byte(nominal[i], 0);
        check("nom_width", width, 3);
        check("nom_height", height, 2);

        send_byte(8'h00, 1);
        send_byte(8'h55, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        send_byte(8'hFF, 2);

        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h41, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h40, 0);
        send_byte(8'h41, 0);

        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h02, 0);
        send_byte(8'hFF, 0);
        for (int i = 0; i < 150 && !err; i++) @(negedge clk);
        check("timeout_err", err, 1);
        check("timeout_delay", cyc - t_acc, 100);
        check("timeout_busy", busy, 0);
        m_state = 0;
        m_err++;
        @(negedge clk);

        send_byte(8'hA5, 0);
        send_byte(8'h04, 0);
        send_byte(8'h04, 0);
        send_byte(8'hC0, 0);
        send_byte(8'h20, 0);
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);

        rx_data = 8'hA5;
        ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("held_err", err, 0);
        end
        check("held_busy", busy, 1);
        ready = 1'b0;
        m_state = 1;
        @(negedge clk);
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        send_byte(8'h90, 0);
        send_byte(8'h05, 0);

        for (int f = 0; f < 30; f++) begin
            r = $urandom_range(0, 9);
            w = $urandom_range(1, 8);
            h = $urandom_range(1, 8);
            if (r == 2) begin w = 64; h = 1; end
            if (r == 3) begin w = 1; h = 64; end
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h00;
                send_byte(g, $urandom_range(0, 3));
            end
            send_byte(8'hA5, $urandom_range(0, 3));
            if (r == 0) send_byte($urandom_range(0, 1) ? 8'($urandom_range(65, 255)) : 8'h00, 1);
            else begin
                send_byte(8'(w), $urandom_range(0, 3));
                if (r == 1) send_byte(8'($urandom_range(65, 255)), 1);
                else begin
                    send_byte(8'(h), $urandom_range(0, 3));
                    repeat (w * h) send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 3));
                end
            end
        end

        repeat (3) @(negedge clk);
        check("total_writes", n_wr_seen, m_wr);
        check("total_errs", n_err_seen, m_err);
        check("total_dones", n_done_seen, m_done);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
